// File: rtl/dkong_input_mapper.sv
// Keyboard/joystick front-end for dkong_top: PS/2 key latches, rotation, opposite-direction
// cleaning and a timed coin pulse. Optional autofire is enabled with INPUT_MAP_AUTOFIRE_EN.

module dkong_input_lane
`ifdef INPUT_MAP_AUTOFIRE_EN
#(
  parameter int AUTOFIRE_HALF = 1228800
)
`endif
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rotate,
  input  logic [4:0] raw,    // [0]R [1]L [2]D [3]U [4]fire
  output logic [4:0] ctl_n   // same layout, active-low
);
  logic [3:0] dir, clean;    // {U,D,L,R}
  logic       fire;

  always_comb begin
    dir   = rotate ? {raw[1], raw[0], raw[2], raw[3]} : raw[3:0];
    clean = dir;
    if (dir[3] && dir[2]) clean[3:2] = 2'b00;
    if (dir[1] && dir[0]) clean[1:0] = 2'b00;
  end

`ifdef INPUT_MAP_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
  logic          fire_q, win, rise;
  logic [AW-1:0] af_cnt;

  // A fresh press forces the window open so the first shot is not delayed.
  assign rise = raw[4] & ~fire_q;
  assign fire = raw[4] & (rise | win);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fire_q <= 1'b0;
      win    <= 1'b0;
      af_cnt <= '0;
    end else begin
      fire_q <= raw[4];
      if (rise) begin
        win    <= 1'b1;
        af_cnt <= AW'(AUTOFIRE_HALF - 2);
      end else if (af_cnt == '0) begin
        win    <= ~win;
        af_cnt <= AW'(AUTOFIRE_HALF - 1);
      end else begin
        af_cnt <= af_cnt - 1'b1;
      end
    end
  end
`else
  assign fire = raw[4];
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) ctl_n <= '1;
    else       ctl_n <= ~{fire, clean};
  end
endmodule

module dkong_input_mapper #(
  parameter int COIN_PULSE_CYCLES = 2457600,
  parameter int COIN_LOCK_CYCLES  = 2457600,
  parameter int AUTOFIRE_HALF     = 1228800
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic        o_u1_n, o_d1_n, o_l1_n, o_r1_n, o_j1_n,
  output logic        o_u2_n, o_d2_n, o_l2_n, o_r2_n, o_j2_n,
  output logic        o_s1_n, o_s2_n,
  output logic        o_c1_n,
  output logic        o_coin_busy
);
  localparam int NUM_PLAYERS = 2;
  localparam int MAXC = (COIN_PULSE_CYCLES > COIN_LOCK_CYCLES)
                        ? ((COIN_PULSE_CYCLES > AUTOFIRE_HALF) ? COIN_PULSE_CYCLES : AUTOFIRE_HALF)
                        : ((COIN_LOCK_CYCLES  > AUTOFIRE_HALF) ? COIN_LOCK_CYCLES  : AUTOFIRE_HALF);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef struct packed {
    logic [4:0] p1;   // joystick bit layout
    logic [4:0] p2;
    logic       s1, s2, coin;
  } key_lat_t;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_LOCK} coin_st_t;

  key_lat_t  lat;
  logic      tog_q, evt, pr;
  logic [8:0] code;
  logic [NUM_PLAYERS-1:0][4:0] raw, ctl_n;
  logic      coin_src, coin_q;
  coin_st_t  st;
  logic [CW-1:0] cnt;
  logic      unused_bits;

  assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8]};
  assign evt  = ps2_key[10] ^ tog_q;
  assign pr   = ps2_key[9];
  assign code = ps2_key[8:0];

  // Reset also resamples the toggle so a pending event during reset is discarded.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (reset) begin
      lat <= '0;
    end else if (evt) begin
      casez (code)
        9'b?0111_0101: lat.p1[3] <= pr;
        9'b?0111_0010: lat.p1[2] <= pr;
        9'b?0110_1011: lat.p1[1] <= pr;
        9'b?0111_0100: lat.p1[0] <= pr;
        9'h029, 9'h014: lat.p1[4] <= pr;
        9'h005, 9'h016: lat.s1    <= pr;
        9'h006, 9'h01E: lat.s2    <= pr;
        9'h02E, 9'h036: lat.coin  <= pr;
        9'h02D: lat.p2[3] <= pr;
        9'h02B: lat.p2[2] <= pr;
        9'h023: lat.p2[1] <= pr;
        9'h034: lat.p2[0] <= pr;
        9'h01C: lat.p2[4] <= pr;
        default: ;
      endcase
    end
  end

  assign raw[0] = lat.p1 | joystick_0[4:0];
  assign raw[1] = lat.p2 | joystick_1[4:0];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    dkong_input_lane
`ifdef INPUT_MAP_AUTOFIRE_EN
      #(.AUTOFIRE_HALF(AUTOFIRE_HALF))
`endif
      u_lane (
      .clk_sys(clk_sys),
      .reset  (reset),
      .rotate (rotate),
      .raw    (raw[p]),
      .ctl_n  (ctl_n[p])
    );
  end

  assign {o_j1_n, o_u1_n, o_d1_n, o_l1_n, o_r1_n} = ctl_n[0];
  assign {o_j2_n, o_u2_n, o_d2_n, o_l2_n, o_r2_n} = ctl_n[1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_s1_n <= 1'b1;
      o_s2_n <= 1'b1;
    end else begin
      o_s1_n <= ~(lat.s1 | joystick_0[5] | joystick_1[5]);
      o_s2_n <= ~(lat.s2 | joystick_0[6] | joystick_1[6]);
    end
  end

  assign coin_src = lat.coin | joystick_0[7] | joystick_1[7];

  // Edges arriving outside IDLE are dropped; a held source needs a fresh rise.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st          <= C_IDLE;
      cnt         <= '0;
      coin_q      <= 1'b0;
      o_c1_n      <= 1'b1;
      o_coin_busy <= 1'b0;
    end else begin
      coin_q <= coin_src;
      case (st)
        C_IDLE: if (coin_src && !coin_q) begin
          st          <= C_PULSE;
          cnt         <= CW'(COIN_PULSE_CYCLES - 1);
          o_c1_n      <= 1'b0;
          o_coin_busy <= 1'b1;
        end
        C_PULSE: if (cnt == '0) begin
          st     <= C_LOCK;
          cnt    <= CW'(COIN_LOCK_CYCLES - 1);
          o_c1_n <= 1'b1;
        end else cnt <= cnt - 1'b1;
        C_LOCK: if (cnt == '0) begin
          st          <= C_IDLE;
          o_coin_busy <= 1'b0;
        end else cnt <= cnt - 1'b1;
        default: begin
          st          <= C_IDLE;
          o_c1_n      <= 1'b1;
          o_coin_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dkong_input_mapper.sv
module tb_dkong_input_mapper;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        rotate;
  logic o_u1_n, o_d1_n, o_l1_n, o_r1_n, o_j1_n;
  logic o_u2_n, o_d2_n, o_l2_n, o_r2_n, o_j2_n;
  logic o_s1_n, o_s2_n, o_c1_n, o_coin_busy;

  dkong_input_mapper #(.COIN_PULSE_CYCLES(8), .COIN_LOCK_CYCLES(8), .AUTOFIRE_HALF(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
    .o_u1_n(o_u1_n), .o_d1_n(o_d1_n), .o_l1_n(o_l1_n), .o_r1_n(o_r1_n), .o_j1_n(o_j1_n),
    .o_u2_n(o_u2_n), .o_d2_n(o_d2_n), .o_l2_n(o_l2_n), .o_r2_n(o_r2_n), .o_j2_n(o_j2_n),
    .o_s1_n(o_s1_n), .o_s2_n(o_s2_n), .o_c1_n(o_c1_n), .o_coin_busy(o_coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  localparam logic [13:0] IDLE = 14'h3FFE;
  localparam logic [13:0] U1 = 14'h2000, D1 = 14'h1000, L1 = 14'h0800, R1 = 14'h0400;
  localparam logic [13:0] J1 = 14'h0200, U2 = 14'h0100, D2 = 14'h0080, L2 = 14'h0040;
  localparam logic [13:0] R2 = 14'h0020, J2 = 14'h0010, S1 = 14'h0008, S2 = 14'h0004;
  localparam logic [13:0] C1 = 14'h0002, BUSY = 14'h0001;

  typedef struct {
    int          cyc;
    logic [13:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  logic tog = 1'b0;
  logic [13:0] outv;

  assign outv = {o_u1_n, o_d1_n, o_l1_n, o_r1_n, o_j1_n, o_u2_n, o_d2_n, o_l2_n, o_r2_n,
                 o_j2_n, o_s1_n, o_s2_n, o_c1_n, o_coin_busy};

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc || outv !== e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got %h (at cyc %0d), expected %h", e.name, e.cyc, outv, cyc, e.val);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input int off, input logic [13:0] v, input string nm);
    exp_t e;
    int   i;
    e.cyc = cyc + off; e.val = v; e.name = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    reset = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;
    tick();
    push(1, IDLE, "reset_state");
    tick(3);
    reset = 1'b0;
    for (int i = 1; i <= 100; i++) push(i, IDLE, "idle");
    tick(100);
    n_cmp++;
    if (o_u1_n !== 1'b1) begin n_bad++; $display("FAIL direct idle o_u1_n=%b", o_u1_n); end
    n_cmp++;
    if (o_c1_n !== 1'b1) begin n_bad++; $display("FAIL direct idle o_c1_n=%b", o_c1_n); end
    n_cmp++;
    if (o_coin_busy !== 1'b0) begin n_bad++; $display("FAIL direct idle busy=%b", o_coin_busy); end

    key(1'b1, 9'h075); push(1, IDLE, "up_lat1"); push(2, IDLE & ~U1, "up_press"); tick(3);
    n_cmp++;
    if (o_u1_n !== 1'b0) begin n_bad++; $display("FAIL direct up_press o_u1_n=%b", o_u1_n); end
    key(1'b0, 9'h075); push(1, IDLE & ~U1, "up_hold"); push(2, IDLE, "up_release"); tick(3);
    n_cmp++;
    if (o_u1_n !== 1'b1) begin n_bad++; $display("FAIL direct up_release o_u1_n=%b", o_u1_n); end
    key(1'b1, 9'h172); push(2, IDLE & ~D1, "down_ext"); tick(3);
    key(1'b0, 9'h172); push(2, IDLE, "down_rel"); tick(3);
    key(1'b1, 9'h129); push(2, IDLE, "ext_029_ignored"); tick(3);
    key(1'b1, 9'h0FF); push(2, IDLE, "unknown_ignored"); tick(3);
    key(1'b1, 9'h029); push(2, IDLE & ~J1, "fire1_key"); tick(3);
    key(1'b0, 9'h029); push(2, IDLE, "fire1_rel"); tick(3);
    key(1'b1, 9'h02D); push(2, IDLE & ~U2, "p2_up"); tick(3);
    key(1'b1, 9'h034); push(2, IDLE & ~U2 & ~R2, "p2_up_right"); tick(3);
    key(1'b1, 9'h023); push(2, IDLE & ~U2, "p2_lr_clean"); tick(3);
    key(1'b0, 9'h02D); tick();
    key(1'b0, 9'h034); tick();
    key(1'b0, 9'h023); push(2, IDLE, "p2_rel"); tick(3);
    key(1'b1, 9'h016); push(2, IDLE & ~S1, "start1_key"); tick(3);
    key(1'b0, 9'h016); push(2, IDLE, "start1_rel"); tick(3);

    rotate = 1'b1; joystick_0 = 16'h0002; push(1, IDLE & ~U1, "rot_left_to_up"); tick();
    n_cmp++;
    if (o_u1_n !== 1'b0 || o_l1_n !== 1'b1) begin
      n_bad++; $display("FAIL direct rot u1=%b l1=%b", o_u1_n, o_l1_n);
    end
    joystick_0 = 16'h0003; push(1, IDLE, "rot_ud_clean"); tick();
    joystick_0 = 16'h0000; rotate = 1'b0; joystick_1 = 16'h0008;
    push(1, IDLE & ~U2, "p2_up_norot"); tick();
    rotate = 1'b1; push(1, IDLE & ~R2, "p2_rot_up_to_right"); tick();
    joystick_1 = 16'h0048; push(1, IDLE & ~R2 & ~S2, "p2_start2"); tick();
    rotate = 1'b0; joystick_1 = 16'h0000; joystick_0 = 16'h0003;
    push(1, IDLE, "lr_clean"); tick();
    joystick_0 = 16'h0001; push(1, IDLE & ~R1, "p1_right"); tick();
    joystick_0 = 16'h0000; push(1, IDLE, "joy_idle"); tick(2);

    joystick_1 = 16'h0080;
    for (int k = 1; k <= 8; k++)   push(k, (IDLE & ~C1) | BUSY, "coin_pulse");
    for (int k = 9; k <= 16; k++)  push(k, IDLE | BUSY, "coin_lock");
    for (int k = 17; k <= 21; k++) push(k, IDLE, "coin_idle_after");
    tick();
    joystick_1 = 16'h0000; tick(9);
    joystick_1 = 16'h0080; tick();
    joystick_1 = 16'h0000; tick(10);

    joystick_0 = 16'h0080;
    for (int k = 1; k <= 8; k++)   push(k, (IDLE & ~C1) | BUSY, "held_pulse");
    for (int k = 9; k <= 16; k++)  push(k, IDLE | BUSY, "held_lock");
    for (int k = 17; k <= 24; k++) push(k, IDLE, "held_no_retrigger");
    tick(24);
    joystick_0 = 16'h0000; tick(2);

    joystick_0 = 16'h0080;
    for (int k = 1; k <= 3; k++) push(k, (IDLE & ~C1) | BUSY, "pre_rst_pulse");
    tick();
    joystick_0 = 16'h0000; tick(2);
    reset = 1'b1; key(1'b1, 9'h075); push(1, IDLE, "rst_mid_pulse"); tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) push(k, IDLE, "rst_event_lost");
    tick(6);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s never checked: expected %h at cyc %0d", e.name, e.val, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
